// File: rtl/bus_target.sv
// bus_target: bus responder with RAM, status/data FIFO port and tick counter, registered read data
module bus_target #(
  parameter int RAM_AW = 11,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RW,
  input  logic [15:0] AD,
  input  logic [7:0]  D_wr,
  output logic [7:0]  D_rd,
  output logic [7:0]  port_data,
  output logic        port_valid,
  input  logic        port_ready
);
  localparam int DEPTH = 1 << FIFO_AW;
  logic [7:0] ram [2**RAM_AW];
  logic [7:0] fifo [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count;
  logic [7:0] tick, rd_val;
  logic ovf, is_ram, full, empty, push, pop, accept, clr;
  always_comb begin
    is_ram = !AD[15];
    full = count == (FIFO_AW+1)'(DEPTH);
    empty = count == '0;
    push = !RW && AD == 16'hF001;
    clr = !RW && AD == 16'hF000;
    pop = !empty && port_ready;
    accept = push && (!full || pop);
    rd_val = is_ram ? ram[AD[RAM_AW-1:0]] :
             AD == 16'hF000 ? {5'b0, ovf, empty, full} :
             AD == 16'hF001 ? 8'h00 :
             AD == 16'hF002 ? tick : 8'hFF;
  end
  assign port_valid = !empty;
  assign port_data = empty ? 8'h00 : fifo[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      D_rd <= 8'h00;
      tick <= 8'h00;
      ovf <= 1'b0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      tick <= tick + 8'd1;
      if (RW) D_rd <= rd_val;
      if (accept) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + (FIFO_AW+1)'(accept) - (FIFO_AW+1)'(pop);
      if (clr) ovf <= 1'b0;
      else if (push && full && !pop) ovf <= 1'b1;
    end
  end
  // Storage is never cleared; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!RW && is_ram) ram[AD[RAM_AW-1:0]] <= D_wr;
      if (accept) fifo[wr_ptr] <= D_wr;
    end
  end
endmodule

// File: tb/tb_bus_target.sv
// tb_bus_target: directed checks of RAM, FIFO port, status, tick and reset behaviour
module tb_bus_target;
  logic clk = 0, rst = 1, RW = 1, port_ready = 0;
  logic [15:0] AD = 16'hFFFF;
  logic [7:0] D_wr = 0, D_rd, port_data;
  logic port_valid;
  int checks = 0, fails = 0;

  bus_target dut (.clk(clk), .rst(rst), .RW(RW), .AD(AD), .D_wr(D_wr), .D_rd(D_rd),
    .port_data(port_data), .port_valid(port_valid), .port_ready(port_ready));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_rd(input logic [15:0] a);
    RW = 1; AD = a;
    cyc();
    AD = 16'hFFFF;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    RW = 0; AD = a; D_wr = d;
    cyc();
    RW = 1; AD = 16'hFFFF;
  endtask

  task automatic do_reset();
    rst = 1; port_ready = 0;
    cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; RW = 1; AD = 16'hFFFF; port_ready = 0;
    cyc(); cyc();
    checks++; if (D_rd !== 8'h00) begin fails++; $display("FAIL reset_drd act=%h exp=00", D_rd); end
    checks++; if (port_valid !== 1'b0) begin fails++; $display("FAIL reset_valid act=%b exp=0", port_valid); end
    checks++; if (port_data !== 8'h00) begin fails++; $display("FAIL reset_pdata act=%h exp=00", port_data); end
    rst = 0;
    bus_rd(16'hF000);
    checks++; if (D_rd !== 8'h02) begin fails++; $display("FAIL reset_status act=%h exp=02", D_rd); end
  endtask

  task automatic test_ram();
    bus_wr(16'h0123, 8'h5A);
    bus_rd(16'h0123);
    checks++; if (D_rd !== 8'h5A) begin fails++; $display("FAIL ram_read act=%h exp=5a", D_rd); end
    bus_rd(16'h0923);
    checks++; if (D_rd !== 8'h5A) begin fails++; $display("FAIL ram_mirror act=%h exp=5a", D_rd); end
    bus_wr(16'h0010, 8'h77);
    checks++; if (D_rd !== 8'h5A) begin fails++; $display("FAIL write_holds_drd act=%h exp=5a", D_rd); end
    bus_rd(16'h0010);
    checks++; if (D_rd !== 8'h77) begin fails++; $display("FAIL ram_read2 act=%h exp=77", D_rd); end
  endtask

  task automatic test_fifo_fill();
    logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    bus_rd(16'hF000);
    checks++; if (D_rd !== 8'h02) begin fails++; $display("FAIL status_empty act=%h exp=02", D_rd); end
    bus_wr(16'hF001, v[0]);
    checks++; if (port_valid !== 1'b1) begin fails++; $display("FAIL first_push_valid act=%b exp=1", port_valid); end
    for (int i = 1; i < 4; i++) bus_wr(16'hF001, v[i]);
    bus_rd(16'hF000);
    checks++; if (D_rd !== 8'h01) begin fails++; $display("FAIL status_full act=%h exp=01", D_rd); end
    checks++; if (port_data !== 8'h11) begin fails++; $display("FAIL head_full act=%h exp=11", port_data); end
    bus_rd(16'hF001);
    checks++; if (D_rd !== 8'h00) begin fails++; $display("FAIL data_read act=%h exp=00", D_rd); end
  endtask

  task automatic test_overflow();
    bus_wr(16'hF001, 8'h55);
    bus_rd(16'hF000);
    checks++; if (D_rd !== 8'h05) begin fails++; $display("FAIL status_ovf act=%h exp=05", D_rd); end
    checks++; if (port_data !== 8'h11) begin fails++; $display("FAIL head_ovf act=%h exp=11", port_data); end
    bus_wr(16'hF000, 8'h00);
    bus_rd(16'hF000);
    checks++; if (D_rd !== 8'h01) begin fails++; $display("FAIL status_clr act=%h exp=01", D_rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    port_ready = 1;
    bus_wr(16'hF001, 8'h66);
    port_ready = 0;
    bus_rd(16'hF000);
    checks++; if (D_rd !== 8'h01) begin fails++; $display("FAIL status_pushpop act=%h exp=01", D_rd); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (port_valid !== 1'b1 || port_data !== e[i]) begin fails++; $display("FAIL drain_%0d act=%b/%h exp=1/%h", i, port_valid, port_data, e[i]); end
      port_ready = 1;
      cyc();
      port_ready = 0;
    end
    checks++; if (port_valid !== 1'b0) begin fails++; $display("FAIL drain_end_valid act=%b exp=0", port_valid); end
    bus_rd(16'hF000);
    checks++; if (D_rd !== 8'h02) begin fails++; $display("FAIL status_drained act=%h exp=02", D_rd); end
  endtask

  task automatic test_tick();
    do_reset();
    bus_rd(16'hF002);
    checks++; if (D_rd !== 8'h00) begin fails++; $display("FAIL tick0 act=%h exp=00", D_rd); end
    repeat (299) cyc();
    bus_rd(16'hF002);
    checks++; if (D_rd !== 8'h2C) begin fails++; $display("FAIL tick300 act=%h exp=2c", D_rd); end
    bus_rd(16'h9000);
    checks++; if (D_rd !== 8'hFF) begin fails++; $display("FAIL unmapped act=%h exp=ff", D_rd); end
    bus_rd(16'hF003);
    checks++; if (D_rd !== 8'hFF) begin fails++; $display("FAIL unmapped2 act=%h exp=ff", D_rd); end
  endtask

  task automatic test_reset_mid();
    bus_wr(16'hF001, 8'hA1);
    bus_wr(16'hF001, 8'hA2);
    bus_wr(16'hF001, 8'hA3);
    bus_rd(16'h0010);
    rst = 1; RW = 0; AD = 16'h0010; D_wr = 8'hAB; port_ready = 1;
    cyc();
    rst = 0; RW = 1; AD = 16'hFFFF; port_ready = 0;
    checks++; if (port_valid !== 1'b0) begin fails++; $display("FAIL midreset_valid act=%b exp=0", port_valid); end
    checks++; if (D_rd !== 8'h00) begin fails++; $display("FAIL midreset_drd act=%h exp=00", D_rd); end
    bus_rd(16'hF000);
    checks++; if (D_rd !== 8'h02) begin fails++; $display("FAIL midreset_status act=%h exp=02", D_rd); end
    bus_rd(16'h0010);
    checks++; if (D_rd !== 8'h77) begin fails++; $display("FAIL midreset_ram act=%h exp=77", D_rd); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_fifo_fill();
    test_overflow();
    test_back_to_back();
    test_tick();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
